// File: rtl/zcash_verif_pkg.sv
// Shared constants and state encoding for the Zcash header stream blocks.
package zcash_verif_pkg;
  localparam int CBLOCKHEADER_BYTS     = 140;
  localparam int EQUIHASH_SOL_LEN_BYTS = 3;
  localparam int EQUIHASH_SOL_BYTS     = 1344;
  localparam int HDR_BYTS_DEF          = CBLOCKHEADER_BYTS + EQUIHASH_SOL_LEN_BYTS + EQUIHASH_SOL_BYTS;

  typedef enum logic [1:0] {IDLE, SEND, TERM} hdr_tx_state_e;
endpackage

// File: rtl/if_axi_stream.sv
// Byte-oriented stream with sop/eop framing, error flag, trailing-byte mod and a tag.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;

  modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/zcash_verif_header_tx.sv
// Streams one parallel-loaded block header out as DAT_BYTS beats; supports
// a mid-frame abort that closes the frame with an errored eop beat.
module zcash_verif_header_tx
  import zcash_verif_pkg::*;
#(
  parameter int HDR_BYTS = HDR_BYTS_DEF,
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [HDR_BYTS*8-1:0] i_hdr,
  input  logic                  i_hdr_val,
  output logic                  o_hdr_rdy,
  input  logic [CTL_BITS-1:0]   i_ctl,
  input  logic                  i_abort,
  if_axi_stream.source          o_axi,
  output logic [31:0]           o_frame_cnt
);
  localparam int NUM_BEATS = (HDR_BYTS + DAT_BYTS - 1) / DAT_BYTS;
  localparam int LAST_MOD  = HDR_BYTS % DAT_BYTS;
  localparam int BEAT_W    = DAT_BYTS * 8;
  localparam int SR_W      = NUM_BEATS * BEAT_W;
  localparam int BCNT_W    = $clog2(NUM_BEATS + 1);
  localparam int MOD_BITS  = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  hdr_tx_state_e       r_state, w_state_nxt;
  logic [SR_W-1:0]     r_sr;
  logic [BCNT_W-1:0]   r_beat;
  logic [CTL_BITS-1:0] r_ctl;
  logic                r_abort_pend;
  logic [31:0]         r_frame_cnt;

  logic w_last, w_hs, w_load, w_shift, w_done, w_abort_set, w_term_done;

  assign w_last = (r_beat == BCNT_W'(NUM_BEATS - 1));
  assign w_hs   = o_axi.val & o_axi.rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_abort_set = 1'b0;
    w_term_done = 1'b0;
    case (r_state)
      IDLE: if (i_hdr_val) begin
        w_load      = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        // An abort landing on the eop beat is moot: the frame is finishing anyway.
        w_abort_set = i_abort & ~w_last;
        if (w_hs) begin
          if (w_last) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_shift = 1'b1;
            if (r_abort_pend | w_abort_set) w_state_nxt = TERM;
          end
        end
      end
      TERM: if (w_hs) begin
        w_term_done = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_beat       <= '0;
      r_ctl        <= '0;
      r_abort_pend <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sr   <= SR_W'(i_hdr);
        r_ctl  <= i_ctl;
        r_beat <= '0;
      end else if (w_shift) begin
        r_sr   <= r_sr >> BEAT_W;
        r_beat <= r_beat + 1'b1;
      end
      if (w_abort_set)      r_abort_pend <= 1'b1;
      else if (w_term_done) r_abort_pend <= 1'b0;
      if (w_done) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  // Outputs decode straight from state so reset drops val without a clock edge.
  assign o_hdr_rdy   = (r_state == IDLE);
  assign o_frame_cnt = r_frame_cnt;
  assign o_axi.val   = (r_state != IDLE);
  assign o_axi.sop   = (r_state == SEND) && (r_beat == '0);
  assign o_axi.eop   = ((r_state == SEND) && w_last) || (r_state == TERM);
  assign o_axi.err   = (r_state == TERM);
  assign o_axi.dat   = (r_state == SEND) ? r_sr[BEAT_W-1:0] : '0;
  assign o_axi.mod   = ((r_state == SEND) && w_last) ? MOD_BITS'(LAST_MOD) : '0;
  assign o_axi.ctl   = (r_state == IDLE) ? '0 : r_ctl;
endmodule

// File: tb/tb_zcash_verif_header_tx.sv
// Random-stimulus bench for zcash_verif_header_tx against a byte-array frame model.
module tb_zcash_verif_header_tx;
  localparam int HA = 1487;
  localparam int NB = (HA + 7) / 8;
  localparam int LM = HA % 8;

  typedef logic [7:0] hdr_t [HA];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int exp_fc = 0;

  // DUT A: full-size header
  logic [HA*8-1:0] hdr_a = '0;
  logic            hv_a = 1'b0, ab_a = 1'b0, hrdy_a;
  logic [7:0]      ctl_a = '0, tag = '0;
  logic [31:0]     fc_a;
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) ax_a();

  zcash_verif_header_tx #(.HDR_BYTS(HA), .DAT_BYTS(8), .CTL_BITS(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_hdr(hdr_a), .i_hdr_val(hv_a), .o_hdr_rdy(hrdy_a),
    .i_ctl(ctl_a), .i_abort(ab_a), .o_axi(ax_a), .o_frame_cnt(fc_a));

  // DUT B: 16-byte header, two full beats
  logic [127:0] hdr_b = '0;
  logic         hv_b = 1'b0, ab_b = 1'b0, hrdy_b;
  logic [7:0]   ctl_b = '0;
  logic [31:0]  fc_b;
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) ax_b();

  zcash_verif_header_tx #(.HDR_BYTS(16), .DAT_BYTS(8), .CTL_BITS(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_hdr(hdr_b), .i_hdr_val(hv_b), .o_hdr_rdy(hrdy_b),
    .i_ctl(ctl_b), .i_abort(ab_b), .o_axi(ax_b), .o_frame_cnt(fc_b));

  // DUT C: 5-byte header, single partial beat
  logic [39:0] hdr_c = '0;
  logic        hv_c = 1'b0, ab_c = 1'b0, hrdy_c;
  logic [7:0]  ctl_c = '0;
  logic [31:0] fc_c;
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) ax_c();

  zcash_verif_header_tx #(.HDR_BYTS(5), .DAT_BYTS(8), .CTL_BITS(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_hdr(hdr_c), .i_hdr_val(hv_c), .o_hdr_rdy(hrdy_c),
    .i_ctl(ctl_c), .i_abort(ab_c), .o_axi(ax_c), .o_frame_cnt(fc_c));

  hdr_t hb, hb2;

  function automatic logic [HA*8-1:0] pack(input hdr_t h);
    logic [HA*8-1:0] p;
    p = '0;
    for (int n = 0; n < HA; n++) p[n*8 +: 8] = h[n];
    return p;
  endfunction

  function automatic logic [63:0] exp_dat(input hdr_t h, input int k);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) if (k*8 + i < HA) d[i*8 +: 8] = h[k*8 + i];
    return d;
  endfunction

  // Loads hb, then follows the frame beat by beat against the model.
  // abort_at < 0 means no abort; hold keeps i_hdr_val high with hb2 queued.
  task automatic run_frame(input int pct, input int abort_at, input bit hold,
                           output int nbeats, output int ncyc,
                           output logic [63:0] d0, output logic [63:0] dl, output logic [2:0] ml);
    int k, cyc;
    bit term, done, aborted, stall;
    logic [63:0] ed, pd;
    logic es, ee, er, ps, pe;
    logic [2:0] em, pm;
    hdr_a = pack(hb); ctl_a = tag; hv_a = 1'b1; ab_a = 1'b0; ax_a.rdy = 1'b0;
    @(posedge clk); #1;
    if (hold) hdr_a = pack(hb2); else hv_a = 1'b0;
    k = 0; cyc = 0; term = 0; done = 0; aborted = 0; stall = 0;
    nbeats = 0; d0 = '0; dl = '0; ml = '0; pd = '0; ps = 0; pe = 0; pm = '0;
    while (!done && cyc < 3000) begin
      if (term) begin ed = '0; es = 0; ee = 1; er = 1; em = '0; end
      else begin
        ed = exp_dat(hb, k); es = (k == 0); ee = (k == NB-1); er = 0;
        em = ee ? 3'(LM) : 3'd0;
      end
      nvec++; if (ax_a.val !== 1'b1) begin nerr++; $display("FAIL val_in_frame beat %0d term %0b: got %b want 1", k, term, ax_a.val); end
      nvec++; if (hrdy_a !== 1'b0) begin nerr++; $display("FAIL hdr_rdy_busy beat %0d: got %b want 0", k, hrdy_a); end
      nvec++; if (ax_a.dat !== ed) begin nerr++; $display("FAIL dat beat %0d term %0b: got %h want %h", k, term, ax_a.dat, ed); end
      nvec++; if ({ax_a.sop, ax_a.eop, ax_a.err} !== {es, ee, er}) begin nerr++; $display("FAIL sop_eop_err beat %0d term %0b: got %b want %b", k, term, {ax_a.sop, ax_a.eop, ax_a.err}, {es, ee, er}); end
      nvec++; if (ax_a.mod !== em) begin nerr++; $display("FAIL mod beat %0d: got %0d want %0d", k, ax_a.mod, em); end
      nvec++; if (ax_a.ctl !== tag) begin nerr++; $display("FAIL ctl beat %0d: got %h want %h", k, ax_a.ctl, tag); end
      if (stall) begin
        nvec++;
        if ({ax_a.dat, ax_a.sop, ax_a.eop, ax_a.mod} !== {pd, ps, pe, pm}) begin
          nerr++; $display("FAIL stall_stable beat %0d: got %h want %h", k, {ax_a.dat, ax_a.sop, ax_a.eop, ax_a.mod}, {pd, ps, pe, pm});
        end
      end
      if (!term && k == 0) d0 = ax_a.dat;
      if (!term && k == NB-1) begin dl = ax_a.dat; ml = ax_a.mod; end
      pd = ax_a.dat; ps = ax_a.sop; pe = ax_a.eop; pm = ax_a.mod;
      ax_a.rdy = ($urandom_range(99) < pct);
      ab_a = (!term && k == abort_at);
      if (ab_a && k != NB-1) aborted = 1;
      stall = !ax_a.rdy;
      @(posedge clk); #1; cyc++;
      if (!stall) begin
        nbeats++;
        if (term) done = 1;
        else if (k == NB-1) begin done = 1; exp_fc++; end
        else if (aborted) term = 1;
        else k++;
      end
    end
    ab_a = 1'b0;
    ncyc = cyc;
    nvec++; if (!done) begin nerr++; $display("FAIL frame_timeout: got %0d cycles want completion", cyc); end
    nvec++; if (ax_a.val !== 1'b0) begin nerr++; $display("FAIL idle_gap_val: got %b want 0", ax_a.val); end
    nvec++; if (hrdy_a !== 1'b1) begin nerr++; $display("FAIL idle_hdr_rdy: got %b want 1", hrdy_a); end
    nvec++; if (fc_a !== 32'(exp_fc)) begin nerr++; $display("FAIL frame_cnt: got %0d want %0d", fc_a, exp_fc); end
  endtask

  task automatic test_reset();
    #12;
    nvec++; if ({ax_a.val, ax_a.sop, ax_a.eop, ax_a.err} !== 4'b0) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {ax_a.val, ax_a.sop, ax_a.eop, ax_a.err}); end
    nvec++; if ({ax_a.dat, ax_a.mod, ax_a.ctl} !== '0) begin nerr++; $display("FAIL rst_dat_mod_ctl: got %h want 0", {ax_a.dat, ax_a.mod, ax_a.ctl}); end
    nvec++; if (fc_a !== 32'd0) begin nerr++; $display("FAIL rst_frame_cnt: got %0d want 0", fc_a); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    nvec++; if (hrdy_a !== 1'b1) begin nerr++; $display("FAIL rst_hdr_rdy: got %b want 1", hrdy_a); end
    nvec++; if (ax_a.val !== 1'b0) begin nerr++; $display("FAIL rst_val: got %b want 0", ax_a.val); end
  endtask

  task automatic test_full();
    int nb, nc; logic [63:0] d0, dl; logic [2:0] ml;
    for (int n = 0; n < HA; n++) hb[n] = 8'(n % 256);
    tag = 8'h5A;
    run_frame(100, -1, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB || nc !== NB) begin nerr++; $display("FAIL full_beats: got %0d beats in %0d cycles want %0d", nb, nc, NB); end
    nvec++; if (d0 !== 64'h0706050403020100) begin nerr++; $display("FAIL full_beat0: got %h want 0706050403020100", d0); end
    nvec++; if (dl !== 64'h00CECDCCCBCAC9C8 || ml !== 3'd7) begin nerr++; $display("FAIL full_last: got %h mod %0d want 00cecdcccbcac9c8 mod 7", dl, ml); end
  endtask

  task automatic test_backpressure();
    int nb, nc; logic [63:0] d0, dl; logic [2:0] ml;
    for (int r = 0; r < 2; r++) begin
      run_frame(50, -1, 0, nb, nc, d0, dl, ml);
      nvec++; if (nb !== NB) begin nerr++; $display("FAIL bp_beats: got %0d want %0d", nb, NB); end
    end
  endtask

  task automatic test_abort();
    int nb, nc; logic [63:0] d0, dl; logic [2:0] ml;
    // abort while idle must not start anything
    ab_a = 1'b1; ax_a.rdy = 1'b1;
    repeat (3) @(posedge clk); #1;
    nvec++; if (ax_a.val !== 1'b0) begin nerr++; $display("FAIL abort_idle_val: got %b want 0", ax_a.val); end
    ab_a = 1'b0;
    for (int n = 0; n < HA; n++) hb[n] = 8'($urandom);
    tag = 8'($urandom);
    run_frame(100, 10, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== 12) begin nerr++; $display("FAIL abort10_beats: got %0d want 12", nb); end
    run_frame(100, -1, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB) begin nerr++; $display("FAIL post_abort_beats: got %0d want %0d", nb, NB); end
    run_frame(50, 0, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== 2) begin nerr++; $display("FAIL abort0_beats: got %0d want 2", nb); end
    run_frame(50, NB-1, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB) begin nerr++; $display("FAIL abort_eop_beats: got %0d want %0d", nb, NB); end
  endtask

  task automatic test_async_reset();
    int nb, nc; logic [63:0] d0, dl; logic [2:0] ml;
    for (int n = 0; n < HA; n++) hb[n] = 8'($urandom);
    hdr_a = pack(hb); ctl_a = tag; hv_a = 1'b1; ax_a.rdy = 1'b1;
    @(posedge clk); #1; hv_a = 1'b0;
    repeat (50) @(posedge clk); #1;
    nvec++; if (ax_a.val !== 1'b1 || ax_a.dat !== exp_dat(hb, 50)) begin nerr++; $display("FAIL pre_rst_beat50: got val %b dat %h want 1 %h", ax_a.val, ax_a.dat, exp_dat(hb, 50)); end
    rst = 1'b1; #1;
    nvec++; if (ax_a.val !== 1'b0) begin nerr++; $display("FAIL async_rst_val: got %b want 0", ax_a.val); end
    nvec++; if (fc_a !== 32'd0) begin nerr++; $display("FAIL async_rst_cnt: got %0d want 0", fc_a); end
    exp_fc = 0;
    @(posedge clk); #1; rst = 1'b0;
    nvec++; if (hrdy_a !== 1'b1) begin nerr++; $display("FAIL post_rst_hdr_rdy: got %b want 1", hrdy_a); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      nvec++; if (ax_a.val !== 1'b0) begin nerr++; $display("FAIL stale_beat cycle %0d: got val %b want 0", i, ax_a.val); end
    end
    run_frame(100, -1, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB) begin nerr++; $display("FAIL post_rst_frame: got %0d want %0d", nb, NB); end
  endtask

  task automatic test_short();
    hdr_b = {$urandom, $urandom, $urandom, $urandom}; ctl_b = 8'($urandom);
    hdr_c = {8'($urandom), $urandom}; ctl_c = 8'($urandom);
    ax_b.rdy = 1'b1; ax_c.rdy = 1'b1; hv_b = 1'b1; hv_c = 1'b1;
    @(posedge clk); #1; hv_b = 1'b0; hv_c = 1'b0;
    nvec++; if ({ax_b.val, ax_b.sop, ax_b.eop, ax_b.err, ax_b.mod} !== 7'b1100_000 || ax_b.dat !== hdr_b[63:0] || ax_b.ctl !== ctl_b) begin
      nerr++; $display("FAIL short16_beat0: got %b %h want 1100000 %h", {ax_b.val, ax_b.sop, ax_b.eop, ax_b.err, ax_b.mod}, ax_b.dat, hdr_b[63:0]); end
    nvec++; if ({ax_c.val, ax_c.sop, ax_c.eop, ax_c.err, ax_c.mod} !== 7'b1110_101 || ax_c.dat !== {24'h0, hdr_c} || ax_c.ctl !== ctl_c) begin
      nerr++; $display("FAIL short5_beat: got %b %h want 1110101 %h", {ax_c.val, ax_c.sop, ax_c.eop, ax_c.err, ax_c.mod}, ax_c.dat, {24'h0, hdr_c}); end
    @(posedge clk); #1;
    nvec++; if ({ax_b.val, ax_b.sop, ax_b.eop, ax_b.err, ax_b.mod} !== 7'b1010_000 || ax_b.dat !== hdr_b[127:64]) begin
      nerr++; $display("FAIL short16_beat1: got %b %h want 1010000 %h", {ax_b.val, ax_b.sop, ax_b.eop, ax_b.err, ax_b.mod}, ax_b.dat, hdr_b[127:64]); end
    nvec++; if (ax_c.val !== 1'b0 || fc_c !== 32'd1) begin nerr++; $display("FAIL short5_done: got val %b cnt %0d want 0 1", ax_c.val, fc_c); end
    @(posedge clk); #1;
    nvec++; if (ax_b.val !== 1'b0 || fc_b !== 32'd1) begin nerr++; $display("FAIL short16_done: got val %b cnt %0d want 0 1", ax_b.val, fc_b); end
  endtask

  task automatic test_back_to_back();
    int nb, nc; logic [63:0] d0, dl; logic [2:0] ml;
    rst = 1'b1; #1; exp_fc = 0;
    @(posedge clk); #1; rst = 1'b0;
    for (int n = 0; n < HA; n++) begin hb[n] = 8'($urandom); hb2[n] = 8'($urandom); end
    tag = 8'h3C;
    run_frame(100, -1, 1, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB) begin nerr++; $display("FAIL b2b_first: got %0d want %0d", nb, NB); end
    hb = hb2;
    run_frame(100, -1, 0, nb, nc, d0, dl, ml);
    nvec++; if (nb !== NB) begin nerr++; $display("FAIL b2b_second: got %0d want %0d", nb, NB); end
    nvec++; if (fc_a !== 32'd2) begin nerr++; $display("FAIL b2b_cnt: got %0d want 2", fc_a); end
  endtask

  initial begin
    ax_a.rdy = 1'b0; ax_b.rdy = 1'b0; ax_c.rdy = 1'b0;
    test_reset();
    test_full();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_short();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
